// File: rtl/frequency_dump_streamer.sv
// Snapshots all f1/f2 action-time values on a dump request and streams them as one
// framed packet (header + f1/f2 per channel) on a valid/ready word stream, then pulses irq.
module frequency_dump_streamer #(
  parameter int          NUM_CHANNELS = 3,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [15:0] HEADER_MAGIC = 16'h029A,
  parameter int          IRQ_PULSE    = 4
) (
  input  logic                               s00_axi_aclk,
  input  logic                               s00_axi_aresetn,
  input  logic                               dump_request,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] f1_values,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] f2_values,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
  output logic                               m_axis_tlast,
  output logic                               busy,
  output logic                               irq,
  output logic [7:0]                         dropped_requests
);

  localparam int NumWords = 2 * NUM_CHANNELS;
  localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1;
  localparam int ChW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int IrqW     = $clog2(IRQ_PULSE + 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumWords - 1);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    DONE
  } state_e;

  state_e                 state_q;
  logic [15:0]            seq_q;
  logic [DATA_WIDTH-1:0]  f1_snap_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]  f2_snap_q [NUM_CHANNELS];
  logic [IdxW-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]  tdata_q;
  logic                   tvalid_q;
  logic                   tlast_q;
  logic [IrqW-1:0]        irq_cnt_q;
  logic [7:0]             dropped_q;

  logic                   handshake;
  logic [IdxW-1:0]        idx_d;
  logic [ChW-1:0]         ch_d;
  logic [DATA_WIDTH-1:0]  word_d;
  logic                   last_d;

  assign handshake = tvalid_q & m_axis_tready;

  // Payload word order is ch0 f1, ch0 f2, ch1 f1, ... so idx[0] picks f1/f2 and idx>>1 the channel.
  always_comb begin
    idx_d = idx_q;
    if (state_q == HEADER) begin
      idx_d = '0;
    end else if (idx_q != LastIdx) begin
      idx_d = idx_q + IdxW'(1);
    end
    ch_d   = ChW'(idx_d >> 1);
    word_d = idx_d[0] ? f2_snap_q[ch_d] : f1_snap_q[ch_d];
    last_d = (idx_d == LastIdx);
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q   <= IDLE;
      seq_q     <= '0;
      idx_q     <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      irq_cnt_q <= '0;
      dropped_q <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        f1_snap_q[k] <= '0;
        f2_snap_q[k] <= '0;
      end
    end else begin
      if (dump_request && (state_q != IDLE) && (dropped_q != 8'hFF)) begin
        dropped_q <= dropped_q + 8'd1;
      end

      // A DONE arriving while irq is still high simply restarts the pulse.
      if (state_q == DONE) begin
        irq_cnt_q <= IrqW'(IRQ_PULSE);
      end else if (irq_cnt_q != '0) begin
        irq_cnt_q <= irq_cnt_q - IrqW'(1);
      end

      unique case (state_q)
        IDLE: begin
          if (dump_request) begin
            for (int k = 0; k < NUM_CHANNELS; k++) begin
              f1_snap_q[k] <= f1_values[k*DATA_WIDTH +: DATA_WIDTH];
              f2_snap_q[k] <= f2_values[k*DATA_WIDTH +: DATA_WIDTH];
            end
            tdata_q  <= DATA_WIDTH'({HEADER_MAGIC, seq_q});
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            state_q  <= HEADER;
          end
        end
        HEADER: begin
          if (handshake) begin
            idx_q   <= idx_d;
            tdata_q <= word_d;
            tlast_q <= last_d;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (handshake) begin
            if (tlast_q) begin
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              tdata_q  <= '0;
              state_q  <= DONE;
            end else begin
              idx_q   <= idx_d;
              tdata_q <= word_d;
              tlast_q <= last_d;
            end
          end
        end
        DONE: begin
          seq_q   <= seq_q + 16'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign m_axis_tdata     = tdata_q;
  assign m_axis_tvalid    = tvalid_q;
  assign m_axis_tlast     = tlast_q;
  assign busy             = (state_q != IDLE);
  assign irq              = (irq_cnt_q != '0);
  assign dropped_requests = dropped_q;

endmodule

// File: tb/tb_frequency_dump_streamer.sv
// Self-checking bench: a queue-based frame model is compared against the streamer every cycle,
// with hand-computed literal frames pinning the model for the directed scenarios.
module tb_frequency_dump_streamer;

  localparam int          NCH   = 3;
  localparam int          DW    = 32;
  localparam int          IRQP  = 4;
  localparam logic [15:0] MAGIC = 16'h029A;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              dumpReq;
  logic [NCH*DW-1:0] f1v;
  logic [NCH*DW-1:0] f2v;
  logic [DW-1:0]     tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              busy;
  logic              irq;
  logic [7:0]        dropped;

  frequency_dump_streamer #(
    .NUM_CHANNELS(NCH),
    .DATA_WIDTH  (DW),
    .HEADER_MAGIC(MAGIC),
    .IRQ_PULSE   (IRQP)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .dump_request    (dumpReq),
    .f1_values       (f1v),
    .f2_values       (f2v),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .m_axis_tlast    (tlast),
    .busy            (busy),
    .irq             (irq),
    .dropped_requests(dropped)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a pending frame is just a queue of words; the front word is on the bus.
  logic [31:0] expQ [$];
  int          mDonePend;
  int          mIrqLeft;
  int          mDropped;
  logic [15:0] mSeq;
  int          mAccepted;

  always @(posedge clk or negedge rst_n) begin
    bit wasBusy;
    if (!rst_n) begin
      expQ.delete();
      mDonePend = 0;
      mIrqLeft  = 0;
      mDropped  = 0;
      mSeq      = 16'h0000;
      mAccepted = 0;
    end else begin
      wasBusy = (expQ.size() != 0) || (mDonePend != 0);
      if (mDonePend != 0) begin
        mSeq      = mSeq + 16'd1;
        mIrqLeft  = IRQP;
        mDonePend = 0;
      end else if (mIrqLeft > 0) begin
        mIrqLeft--;
      end
      if ((expQ.size() != 0) && tready) begin
        void'(expQ.pop_front());
        mAccepted++;
        if (expQ.size() == 0) mDonePend = 1;
      end
      if (dumpReq) begin
        if (wasBusy) begin
          if (mDropped < 255) mDropped++;
        end else begin
          expQ.push_back({MAGIC, mSeq});
          for (int k = 0; k < NCH; k++) begin
            expQ.push_back(f1v[k*DW +: DW]);
            expQ.push_back(f2v[k*DW +: DW]);
          end
        end
      end
    end
  end

  bit cmpEn = 1'b0;

  always @(negedge clk) begin
    if (rst_n && cmpEn) begin
      checkOutput("tvalid", {31'd0, tvalid}, {31'd0, expQ.size() != 0});
      if (expQ.size() != 0) begin
        checkOutput("tdata", tdata, expQ[0]);
        checkOutput("tlast", {31'd0, tlast}, {31'd0, expQ.size() == 1});
      end
      checkOutput("busy", {31'd0, busy}, {31'd0, (expQ.size() != 0) || (mDonePend != 0)});
      checkOutput("irq", {31'd0, irq}, {31'd0, mIrqLeft > 0});
      checkOutput("dropped", {24'd0, dropped}, 32'(mDropped));
    end
  end

  // Accepted-word log used by the literal checks.
  logic [31:0] gotQ [$];
  bit          lastQ [$];
  int          gotCyc [$];
  int          cyc = 0;
  int          irqCnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && tvalid && tready) begin
      gotQ.push_back(tdata);
      lastQ.push_back(tlast);
      gotCyc.push_back(cyc);
    end
  end

  always @(negedge clk) if (irq) irqCnt++;

  bit toggleEn = 1'b0;
  always @(negedge clk) if (toggleEn) tready = ~tready;

  task automatic clearLog();
    gotQ.delete();
    lastQ.delete();
    gotCyc.delete();
  endtask

  task automatic applyStimulus(input bit req);
    dumpReq = req;
    @(negedge clk);
    dumpReq = 1'b0;
  endtask

  task automatic setValues(input logic [31:0] a0, a1, a2, b0, b1, b2);
    f1v = {a2, a1, a0};
    f2v = {b2, b1, b0};
  endtask

  task automatic waitIdle(input string name, input int budget);
    int n = 0;
    while (((expQ.size() != 0) || (mDonePend != 0)) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(n >= budget), 32'd0);
  endtask

  task automatic checkFrame(input string name, input int base, input logic [31:0] hdr,
                            input logic [31:0] a0, a1, a2, b0, b1, b2);
    logic [31:0] exp [7];
    exp = '{hdr, a0, b0, a1, b1, a2, b2};
    checkOutput({name, "_len"}, 32'(gotQ.size() >= base + 7), 32'd1);
    if (gotQ.size() >= base + 7) begin
      for (int i = 0; i < 7; i++) begin
        checkOutput($sformatf("%s_w%0d", name, i), gotQ[base+i], exp[i]);
        checkOutput($sformatf("%s_last%0d", name, i), {31'd0, lastQ[base+i]}, {31'd0, i == 6});
      end
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int n;
    rst_n   = 1'b0;
    dumpReq = 1'b0;
    tready  = 1'b0;
    f1v     = '0;
    f2v     = '0;
    #12;
    checkOutput("rst_tvalid", {31'd0, tvalid}, 32'd0);
    checkOutput("rst_tlast", {31'd0, tlast}, 32'd0);
    checkOutput("rst_tdata", tdata, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
    checkOutput("rst_dropped", {24'd0, dropped}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmpEn = 1'b1;
    @(negedge clk);

    // Basic frame with an always-ready consumer.
    setValues(10, 20, 30, 11, 21, 31);
    tready = 1'b1;
    clearLog();
    irqCnt = 0;
    applyStimulus(1'b1);
    waitIdle("t1_timeout", 50);
    repeat (IRQP + 3) @(negedge clk);
    checkFrame("t1", 0, 32'h029A0000, 10, 20, 30, 11, 21, 31);
    checkOutput("t1_count", 32'(gotQ.size()), 32'd7);
    if (gotCyc.size() == 7) checkOutput("t1_consecutive", 32'(gotCyc[6] - gotCyc[0]), 32'd6);
    checkOutput("t1_irq_cycles", 32'(irqCnt), 32'd4);

    // Consumer toggling ready every cycle.
    clearLog();
    toggleEn = 1'b1;
    applyStimulus(1'b1);
    waitIdle("t2_timeout", 100);
    toggleEn = 1'b0;
    tready = 1'b1;
    repeat (IRQP + 2) @(negedge clk);
    checkFrame("t2", 0, 32'h029A0001, 10, 20, 30, 11, 21, 31);
    checkOutput("t2_count", 32'(gotQ.size()), 32'd7);

    // Inputs change and requests arrive mid-frame: snapshot holds, requests are dropped.
    setValues(100, 200, 300, 101, 201, 301);
    clearLog();
    applyStimulus(1'b1);
    for (int i = 0; i < 6; i++) begin
      f1v = {$urandom, $urandom, $urandom};
      f2v = {$urandom, $urandom, $urandom};
      dumpReq = (i % 2 == 1);
      @(negedge clk);
    end
    dumpReq = 1'b0;
    waitIdle("t3_timeout", 50);
    repeat (IRQP + 2) @(negedge clk);
    checkFrame("t3", 0, 32'h029A0002, 100, 200, 300, 101, 201, 301);
    checkOutput("t3_count", 32'(gotQ.size()), 32'd7);
    checkOutput("t3_dropped", {24'd0, dropped}, 32'd3);

    // Sequence number wrap.
    force dut.seq_q = 16'hFFFF;
    mSeq = 16'hFFFF;
    #1;
    release dut.seq_q;
    @(negedge clk);
    setValues(1, 2, 3, 4, 5, 6);
    clearLog();
    applyStimulus(1'b1);
    waitIdle("t4a_timeout", 50);
    @(negedge clk);
    applyStimulus(1'b1);
    waitIdle("t4b_timeout", 50);
    repeat (IRQP + 2) @(negedge clk);
    checkOutput("t4_count", 32'(gotQ.size()), 32'd14);
    if (gotQ.size() == 14) begin
      checkOutput("t4_hdr_ffff", gotQ[0], 32'h029AFFFF);
      checkOutput("t4_hdr_wrap", gotQ[7], 32'h029A0000);
    end

    // Async reset after the third accepted word.
    applyStimulus(1'b1);
    base = mAccepted;
    n = 0;
    while ((mAccepted - base < 3) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_wait_timeout", 32'(n >= 50), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_tvalid", {31'd0, tvalid}, 32'd0);
    checkOutput("t5_busy", {31'd0, busy}, 32'd0);
    checkOutput("t5_irq", {31'd0, irq}, 32'd0);
    checkOutput("t5_dropped", {24'd0, dropped}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    setValues(7, 8, 9, 17, 18, 19);
    clearLog();
    applyStimulus(1'b1);
    waitIdle("t5_timeout", 50);
    repeat (IRQP + 2) @(negedge clk);
    checkFrame("t5", 0, 32'h029A0000, 7, 8, 9, 17, 18, 19);
    checkOutput("t5_count", 32'(gotQ.size()), 32'd7);

    // Dropped-request counter saturation under a long stall.
    tready = 1'b0;
    applyStimulus(1'b1);
    dumpReq = 1'b1;
    repeat (300) @(negedge clk);
    dumpReq = 1'b0;
    @(negedge clk);
    checkOutput("t6_dropped_sat", {24'd0, dropped}, 32'd255);
    checkOutput("t6_still_valid", {31'd0, tvalid}, 32'd1);
    tready = 1'b1;
    waitIdle("t6_timeout", 50);
    repeat (IRQP + 2) @(negedge clk);

    // Randomized traffic after a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 600; i++) begin
      f1v     = {$urandom, $urandom, $urandom};
      f2v     = {$urandom, $urandom, $urandom};
      dumpReq = ($urandom_range(0, 7) == 0);
      tready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    dumpReq = 1'b0;
    tready  = 1'b1;
    waitIdle("rand_timeout", 50);
    repeat (IRQP + 2) @(negedge clk);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
